tri_raster_walk: RTL

//  Consumer side of the triangle-setup handshake: accepts 3 edge equations + bounding box when

---
 rtl/tri_raster_walk_pkg.sv | 21 ++
 rtl/tri_raster_walk_edge_fn_step.sv | 90 +++++++++
 rtl/tri_raster_walk.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tri_raster_walk_pkg.sv
// Shared types and sizing for the triangle raster walker.
//   EW          : signed width of edge accumulators
//   H_RES_DEF   : default horizontal resolution
//   V_RES_DEF   : default vertical resolution
//   walk_state_t: walker FSM states
//   edge_acc_t  : edge function accumulator type
package raster_pkg;

   localparam int unsigned EW        = 20;
   localparam int unsigned H_RES_DEF = 320;
   localparam int unsigned V_RES_DEF = 240;
   localparam int unsigned XW        = 9;
   localparam int unsigned YW        = 8;
   localparam int unsigned AW        = 9;
   localparam int unsigned CW        = 17;

   typedef enum logic [1:0] {IDLE, INIT, WALK, DONE} walk_state_t;

   typedef logic signed [EW-1:0] edge_acc_t;

endpackage

// File: rtl/tri_raster_walk_edge_fn_step.sv
// One incremental edge function E(x,y) = a*x + b*y + c.
// Optional macro TOP_LEFT_RULE_EN selects the top-left fill rule for E == 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : latch a_in/b_in/c_in
//   init          : E_row = E = a*xi + b*yi + c
//   step_x        : E += a
//   step_y        : E_row += b, E = E_row + b
//   a_in,b_in,c_in: signed coefficients
//   xi, yi        : box origin (unsigned)
//   inside_c      : current E passes the inside test (combinational)
module edge_fn_step
   import raster_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 init,
   input  logic                 step_x,
   input  logic                 step_y,
   input  logic signed [AW-1:0] a_in,
   input  logic signed [AW-1:0] b_in,
   input  logic signed [CW-1:0] c_in,
   input  logic [XW-1:0]        xi,
   input  logic [YW-1:0]        yi,
   output logic                 inside_c
);

   logic signed [AW-1:0] a_r;
   logic signed [AW-1:0] b_r;
   logic signed [CW-1:0] c_r;
   edge_acc_t            e_row;
   edge_acc_t            e;
   edge_acc_t            a_e;
   edge_acc_t            b_e;
   edge_acc_t            c_e;
   edge_acc_t            x_e;
   edge_acc_t            y_e;
   edge_acc_t            e_init_c;

   // Coefficients sign-extend, coordinates zero-extend.
   always_comb begin
      a_e      = edge_acc_t'(a_r);
      b_e      = edge_acc_t'(b_r);
      c_e      = edge_acc_t'(c_r);
      x_e      = edge_acc_t'(xi);
      y_e      = edge_acc_t'(yi);
      e_init_c = a_e * x_e + b_e * y_e + c_e;
   end

   // Coefficient latch and accumulators; no control asserted means hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         c_r   <= '0;
         e_row <= '0;
         e     <= '0;
      end else begin
         if (load) begin
            a_r <= a_in;
            b_r <= b_in;
            c_r <= c_in;
         end
         if (init) begin
            e_row <= e_init_c;
            e     <= e_init_c;
         end else if (step_y) begin
            e_row <= e_row + b_e;
            e     <= e_row + b_e;
         end else if (step_x) begin
            e     <= e + a_e;
         end
      end
   end

`ifdef TOP_LEFT_RULE_EN
   logic top_left_c;
   // Top/left edge: a > 0, or horizontal (a == 0) with b < 0.
   always_comb begin
      top_left_c = (!a_r[AW-1] && (a_r != '0)) || ((a_r == '0) && b_r[AW-1]);
      inside_c   = (!e[EW-1] && (e != '0)) || ((e == '0) && top_left_c);
   end
`else
   always_comb begin
      inside_c = !e[EW-1];
   end
`endif

endmodule

// File: rtl/tri_raster_walk.sv
// Triangle raster walker: latches three edge equations and a bounding box
// on raster_start, walks the box in scanline order and emits covered pixels
// over a valid/ready port. Optional macro: TOP_LEFT_RULE_EN (fill rule).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   raster_start        : start pulse, coefficients/box valid this cycle
//   a1..b3 / c1..c3     : signed edge coefficients / constants
//   bbxi,bbxf,bbyi,bbyf : bounding box (clamped to the screen)
//   raster_busy         : walk in progress
//   raster_done         : one-cycle completion pulse
//   pix_valid,pix_ready : pixel handshake
//   pix_x, pix_y        : covered pixel coordinate
module tri_raster_walk
   import raster_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEF,
   parameter int unsigned V_RES = V_RES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 raster_start,
   input  logic signed [AW-1:0] a1,
   input  logic signed [AW-1:0] b1,
   input  logic signed [AW-1:0] a2,
   input  logic signed [AW-1:0] b2,
   input  logic signed [AW-1:0] a3,
   input  logic signed [AW-1:0] b3,
   input  logic signed [CW-1:0] c1,
   input  logic signed [CW-1:0] c2,
   input  logic signed [CW-1:0] c3,
   input  logic [XW-1:0]        bbxi,
   input  logic [XW-1:0]        bbxf,
   input  logic [YW-1:0]        bbyi,
   input  logic [YW-1:0]        bbyf,
   output logic                 raster_busy,
   output logic                 raster_done,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [XW-1:0]        pix_x,
   output logic [YW-1:0]        pix_y
);

   walk_state_t   state, state_n;
   logic [XW-1:0] xi_r, xf_r, cx, cx_n, xf_cl_c;
   logic [YW-1:0] yi_r, yf_r, cy, cy_n, yf_cl_c;
   logic          exhausted, exhausted_n;
   logic          busy_n, done_n, pv_n;
   logic [XW-1:0] px_n;
   logic [YW-1:0] py_n;
   logic          load_c, init_c, step_x_c, step_y_c;
   logic          advance_c, last_c, covered_c;
   logic [2:0]    inside_c;

   // Edge accumulators.
   edge_fn_step u_edge1 (.clk(clk), .rst(rst), .load(load_c), .init(init_c),
      .step_x(step_x_c), .step_y(step_y_c), .a_in(a1), .b_in(b1), .c_in(c1),
      .xi(xi_r), .yi(yi_r), .inside_c(inside_c[0]));
   edge_fn_step u_edge2 (.clk(clk), .rst(rst), .load(load_c), .init(init_c),
      .step_x(step_x_c), .step_y(step_y_c), .a_in(a2), .b_in(b2), .c_in(c2),
      .xi(xi_r), .yi(yi_r), .inside_c(inside_c[1]));
   edge_fn_step u_edge3 (.clk(clk), .rst(rst), .load(load_c), .init(init_c),
      .step_x(step_x_c), .step_y(step_y_c), .a_in(a3), .b_in(b3), .c_in(c3),
      .xi(xi_r), .yi(yi_r), .inside_c(inside_c[2]));

   // Walk control: the candidate (cx,cy) moves into the output register on
   // each advance; after the last candidate one more advance drains it.
   always_comb begin
      state_n     = state;
      cx_n        = cx;
      cy_n        = cy;
      exhausted_n = exhausted;
      pv_n        = pix_valid;
      px_n        = pix_x;
      py_n        = pix_y;
      load_c      = 1'b0;
      init_c      = 1'b0;
      step_x_c    = 1'b0;
      step_y_c    = 1'b0;

      xf_cl_c   = (32'(bbxf) > H_RES - 1) ? XW'(H_RES - 1) : bbxf;
      yf_cl_c   = (32'(bbyf) > V_RES - 1) ? YW'(V_RES - 1) : bbyf;
      advance_c = !pix_valid || pix_ready;
      last_c    = (cx == xf_r) && (cy == yf_r);
      covered_c = &inside_c;

      case (state)
         IDLE: begin
            if (raster_start) begin
               load_c      = 1'b1;
               cx_n        = bbxi;
               cy_n        = bbyi;
               exhausted_n = 1'b0;
               state_n     = ((bbxi > xf_cl_c) || (bbyi > yf_cl_c)) ? DONE : INIT;
            end
         end
         INIT: begin
            init_c  = 1'b1;
            state_n = WALK;
         end
         WALK: begin
            if (advance_c) begin
               if (exhausted) begin
                  pv_n    = 1'b0;
                  state_n = DONE;
               end else begin
                  pv_n = covered_c;
                  px_n = cx;
                  py_n = cy;
                  if (last_c) begin
                     exhausted_n = 1'b1;
                  end else if (cx < xf_r) begin
                     step_x_c = 1'b1;
                     cx_n     = cx + XW'(1);
                  end else begin
                     step_y_c = 1'b1;
                     cx_n     = xi_r;
                     cy_n     = cy + YW'(1);
                  end
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n == INIT) || (state_n == WALK);
      done_n = (state_n == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         xi_r        <= '0;
         xf_r        <= '0;
         yi_r        <= '0;
         yf_r        <= '0;
         cx          <= '0;
         cy          <= '0;
         exhausted   <= 1'b0;
         raster_busy <= 1'b0;
         raster_done <= 1'b0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
      end else begin
         state       <= state_n;
         cx          <= cx_n;
         cy          <= cy_n;
         exhausted   <= exhausted_n;
         raster_busy <= busy_n;
         raster_done <= done_n;
         pix_valid   <= pv_n;
         pix_x       <= px_n;
         pix_y       <= py_n;
         if (load_c) begin
            xi_r <= bbxi;
            xf_r <= xf_cl_c;
            yi_r <= bbyi;
            yf_r <= yf_cl_c;
         end
      end
   end

endmodule
